pc_fetch_ctrl: RTL and testbench

Fetch sequencer for the program-counter register. It drives the PC register's enable, load and load-value inputs, issues one-outstanding instruction-memory requests at the current PC, and buffers each returned instruction in a one-entry valid/ready output stage. It also squashes in-flight fetches on branch redirects and traps. It sits between the PC register, the instruction memory port and the decode stage.

---
 rtl/pc_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives the PC register controls, issues one-outstanding
// instruction fetches at pc_cur and holds each result in a one-entry output buffer.
module pc_fetch_ctrl #(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    input  logic [31:0] pc_cur,
    output logic        pc_en,
    output logic        pc_load,
    output logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_squash, w_squash_next;
    logic [31:0] r_req_pc, w_req_pc_next;
    logic        r_inst_valid, w_inst_valid_next;
    logic [31:0] r_inst, w_inst_next;
    logic [31:0] r_inst_pc, w_inst_pc_next;

    logic        w_drain;
    logic        w_redir;
    logic        w_capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_squash     <= 1'b0;
            r_req_pc     <= 32'd0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_squash     <= w_squash_next;
            r_req_pc     <= w_req_pc_next;
            r_inst_valid <= w_inst_valid_next;
            r_inst       <= w_inst_next;
            r_inst_pc    <= w_inst_pc_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_squash_next     = r_squash;
        w_req_pc_next     = r_req_pc;
        w_inst_valid_next = r_inst_valid;
        w_inst_next       = r_inst;
        w_inst_pc_next    = r_inst_pc;
        w_capture         = 1'b0;
        pc_en             = 1'b0;
        pc_load           = 1'b0;
        pc_in             = 32'd0;
        imem_req          = 1'b0;
        imem_addr         = pc_cur;

        w_drain = r_inst_valid & inst_ready;
        w_redir = (trap | redirect_valid) & ((r_state == S_REQ) | (r_state == S_WAIT));

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start)
                    w_state_next = S_REQ;
            end
            S_REQ: begin
                imem_req = ~r_inst_valid | w_drain;
                if (imem_req & imem_gnt) begin
                    w_state_next  = S_WAIT;
                    w_req_pc_next = pc_cur;
                    // A fetch granted alongside a redirect fetches the old path.
                    w_squash_next = w_redir;
                end else if (halt_req) begin
                    w_state_next = S_HALTED;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_squash_next = 1'b0;
                    w_state_next  = halt_req ? S_HALTED : S_REQ;
                    if (!w_redir && !r_squash) begin
                        w_capture = 1'b1;
                        pc_en     = 1'b1;
                    end
                end else if (w_redir) begin
                    w_squash_next = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_redir) begin
            pc_en   = 1'b1;
            pc_load = 1'b1;
            pc_in   = trap ? TRAP_VEC : redirect_pc;
        end

        if (w_redir) begin
            w_inst_valid_next = 1'b0;
        end else if (w_capture) begin
            w_inst_valid_next = 1'b1;
            w_inst_next       = imem_rdata;
            w_inst_pc_next    = r_req_pc;
        end else if (w_drain) begin
            w_inst_valid_next = 1'b0;
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign state      = r_state;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a PC-register model, a latency-controlled
// memory model and a scoreboard that checks every accepted instruction.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        trap = 1'b0;
    logic [31:0] pc_cur;
    logic        pc_en, pc_load;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst, inst_pc;
    logic        inst_ready = 1'b1;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int pc_en_cnt = 0;
    int pc_load_cnt = 0;
    int pop_cnt = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap(trap),
        .pc_cur(pc_cur), .pc_en(pc_en), .pc_load(pc_load), .pc_in(pc_in),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .state(state)
    );

    // PC register model
    logic [31:0] r_pc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pc <= 32'd0;
        else if (pc_en)
            r_pc <= pc_load ? pc_in : r_pc + 32'd4;
    end
    assign pc_cur = r_pc;

    // Memory model: always grants, responds mem_lat cycles after the grant; not reset by rst
    int          mem_lat = 1;
    logic        r_pend = 1'b0;
    int          r_cnt = 0;
    logic [31:0] r_mem_addr = 32'd0;
    assign imem_gnt    = 1'b1;
    assign imem_rvalid = r_pend && (r_cnt == 0);
    assign imem_rdata  = 32'hC0DE_0000 ^ r_mem_addr;
    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            r_pend     <= 1'b1;
            r_cnt      <= mem_lat - 1;
            r_mem_addr <= imem_addr;
        end else if (r_pend) begin
            if (r_cnt == 0) r_pend <= 1'b0;
            else r_cnt <= r_cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Scoreboard monitor: pops one expectation per accepted instruction
    always @(negedge clk) begin
        if (!rst) begin
            if (pc_en) pc_en_cnt++;
            if (pc_load) pc_load_cnt++;
            if (inst_valid && inst_ready) begin
                pop_cnt++;
                if (exp_pc_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got pc 0x%08h inst 0x%08h, required none", inst_pc, inst);
                end else begin
                    chk("sb_inst_pc", inst_pc, exp_pc_q.pop_front());
                    chk("sb_inst", inst, exp_inst_q.pop_front());
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins);
        exp_pc_q.push_back(pc);
        exp_inst_q.push_back(ins);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_addr(input logic [31:0] a);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == a) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL timeout_req_addr: no request to 0x%08h, required within 60 cycles", a);
        end
    endtask

    task automatic wait_inst_valid();
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (inst_valid) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL timeout_inst_valid: inst_valid stayed 0, required 1 within 60 cycles");
        end
    endtask

    task automatic pulse_start();
        step(); start = 1'b1;
        step(); start = 1'b0;
    endtask

    int saved_en;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_outputs", {27'd0, inst_valid, imem_req, pc_en, pc_load, 1'b0}, 32'd0);
        chk("rst_pc_in", pc_in, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        step(); rst = 1'b0;

        // Sequential fetch of 0,4,8 then halt while the third is in flight
        push_exp(32'h0, 32'hC0DE_0000);
        push_exp(32'h4, 32'hC0DE_0004);
        push_exp(32'h8, 32'hC0DE_0008);
        pulse_start();
        wait_req_addr(32'h8);
        step(); halt_req = 1'b1;
        repeat (3) step();
        chk("halt_state", {30'd0, state}, 32'd3);
        chk("halt_no_req", {31'd0, imem_req}, 32'd0);
        chk("seq_pc_en_cnt", pc_en_cnt, 32'd3);
        chk("seq_pc_load_cnt", pc_load_cnt, 32'd0);
        chk("seq_popped", pop_cnt, 32'd3);

        // Resume with decode stalled: no request while buffer is full
        halt_req = 1'b0;
        inst_ready = 1'b0;
        push_exp(32'hC, 32'hC0DE_000C);
        pulse_start();
        wait_inst_valid();
        chk("resume_inst_pc", inst_pc, 32'hC);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        step(); inst_ready = 1'b1; mem_lat = 3;
        @(negedge clk);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h10);

        // Redirect while the fetch of 0x10 is outstanding
        step(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        chk("redir_state_wait", {30'd0, state}, 32'd2);
        chk("redir_ctrl", {30'd0, pc_en, pc_load}, 32'd3);
        chk("redir_pc_in", pc_in, 32'h200);
        step(); redirect_valid = 1'b0; redirect_pc = 32'd0;
        saved_en = pc_en_cnt;
        @(negedge clk);
        chk("squash_still_wait", {30'd0, state}, 32'd2);
        wait_req_addr(32'h200);
        mem_lat = 1;
        inst_ready = 1'b0;
        #1;
        chk("squash_no_pc_en", pc_en_cnt, saved_en);
        chk("squash_inst_valid", {31'd0, inst_valid}, 32'd0);

        // Trap and redirect together while a captured instruction sits in the buffer
        wait_inst_valid();
        chk("buf_inst_pc", inst_pc, 32'h200);
        chk("buf_inst", inst, 32'hC0DE_0200);
        step(); trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        chk("trap_ctrl", {30'd0, pc_en, pc_load}, 32'd3);
        chk("trap_pc_in", pc_in, 32'h100);
        step(); trap = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b1;
        push_exp(32'h100, 32'hC0DE_0100);
        @(negedge clk);
        chk("trap_flush", {31'd0, inst_valid}, 32'd0);
        chk("trap_req", {31'd0, imem_req}, 32'd1);
        chk("trap_addr", imem_addr, 32'h100);
        step(); halt_req = 1'b1;
        repeat (3) step();
        chk("trap_halt_state", {30'd0, state}, 32'd3);
        chk("trap_popped", pop_cnt, 32'd5);

        // Reset while a fetch is outstanding; the late response must be ignored
        halt_req = 1'b0; mem_lat = 3;
        pulse_start();
        wait_req_addr(32'h104);
        step(); rst = 1'b1;
        @(negedge clk);
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_outputs", {28'd0, inst_valid, imem_req, pc_en, pc_load}, 32'd0);
        step(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {28'd0, state, inst_valid, pc_en}, 32'd0);
            step();
        end
        chk("queue_empty", exp_pc_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
